cvxif_mac_engine: RTL and testbench
===================================

# cvxif_mac_engine

Multiply-accumulate consumer for the CVXIF non-addressed register banks. It sits directly downstream of two register banks (operand A and operand B) that are loaded sequentially by the coprocessor write-back path. On `start_i` it walks the first `len_i` entries of both banks, multiplying element pairs and summing the products. It then offers the dot product on a valid/ready result port and pulses `dump_o` so the upstream banks and their write pointers are cleared for the next load.

## Interface
- `NB_OF_REGS`, 150: entries per bank.
- `REG_WIDTH`, 9: bits per entry.
- `SIGNED_REGS`, 0: 1 = entries and products are two's-complement; 0 = unsigned.
- `ACC_WIDTH`, 32: accumulator and result width. Must be ≥ 2*REG_WIDTH.
- `LEN_WIDTH`, 9: width of `len_i`.

Ports:
- `clk_i` in 1: single clock; all state updates on its rising edge.
- `rst_i` in 1: reset, asynchronous, active-high.
- `start_i` in 1: start request; sampled only in IDLE.
- `abort_i` in 1: synchronous abort; returns to IDLE with no result and no dump.
- `len_i` in LEN_WIDTH: element count; latched on start.
- `a_regs_i` in NB_OF_REGS×REG_WIDTH: operand bank A.
- `b_regs_i` in NB_OF_REGS×REG_WIDTH: operand bank B.
- `result_o` out ACC_WIDTH: dot product; valid only while `valid_o`=1.
- `valid_o` out 1: result available.
- `ready_i` in 1: consumer accepts the result.
- `busy_o` out 1: high in every state except IDLE.
- `dump_o` out 1: one-cycle clear pulse to the upstream banks.

## Operation
- **States:** IDLE, RUN, DRAIN, DONE.
- **IDLE + `start_i`:**
  - Latch `len_q = min(len_i, NB_OF_REGS)`.
  - Set `acc = 0`, `idx = 0`, `pv = 0`.
  - Next state is RUN if `len_q` > 0, otherwise DRAIN.
- **RUN (each edge):**
  - `prod <= ext(a[idx]) * ext(b[idx])`, `pv <= 1`, `idx <= idx + 1`.
  - If `pv`, `acc <= acc + ext(prod)`.
  - When `idx == len_q-1`, next state is DRAIN.
- **DRAIN (one edge):**
  - If `pv`, `acc <= acc + ext(prod)`.
  - `pv <= 0`, next state DONE.
- **DONE:**
  - `valid_o = 1`, `result_o = acc`, held stable until `ready_i`.
  - On `valid_o && ready_i`: next state IDLE, and `dump_o` is registered high for exactly the following cycle.
- **Arithmetic:**
  - `ext` zero-extends, or sign-extends when `SIGNED_REGS`=1.
  - Products are 2*REG_WIDTH bits, extended to ACC_WIDTH.
  - Accumulation wraps modulo 2^ACC_WIDTH; no saturation and no overflow flag.
- **Abort:** `abort_i` in any state forces IDLE and clears `pv`, `valid_o` and `busy_o` at the next edge. `acc` is not exposed after an abort.
- **`abort_i` vs handshake:** if `abort_i` and a handshake occur on the same edge, `abort_i` wins and `dump_o` stays low.
- **`start_i` outside IDLE:** ignored, no queuing.
- **Operand stability:** bank contents are read live every RUN cycle and must be stable from start until DRAIN. The upstream bank only changes on write-enable, so the controlling FSM must not write during `busy_o`.

## Timing
- **Reset values:** `rst_i` asserted asynchronously drives state = IDLE and clears `idx`, `len_q`, `acc`, `prod`, `pv`, `result_o`, `valid_o`, `busy_o` and `dump_o` to 0.
- **Reset mid-operation:** same as above. No result is produced and no dump is issued.
- **Latency:** start accepted at edge T0 gives `valid_o` high after edge T(len_q+1).
  - `len_q`=0 gives `valid_o` after T1.
  - Throughput is 1 element per cycle.
- **Handshake:**
  - `valid_o` falls after the handshake edge.
  - `dump_o` is high for the one cycle after the handshake edge.
  - The earliest next start is sampled at the edge after the handshake.
- **Combinational paths:** none from inputs to outputs. All outputs are registered or decoded from state.

## Test plan
- **Unsigned basic:** unsigned, `len_i`=3, A={1,2,3}, B={4,5,6}, `ready_i`=1 → `result_o`=32 with `valid_o` after T4. `dump_o` high for exactly 1 cycle after T4, then back to IDLE.
- **Signed:** `SIGNED_REGS`=1, `len_i`=2, A={9'h1FF, 9'h002}, B={9'd5, 9'h1FE} → -5 + (-4) = 32'hFFFFFFF7.
- **Empty and clamped length:**
  - `len_i`=0 → `valid_o` after T1, `result_o`=0.
  - `len_i`=200 with NB=150 and all entries 1 → `result_o`=150 after T151.
- **Backpressure:**
  - Hold `ready_i`=0 for 5 cycles in DONE → `result_o` stable, `busy_o`=1, `dump_o`=0 throughout.
  - Raise `ready_i` → single `dump_o` pulse.
  - A `start_i` pulsed during DONE is ignored.
- **Reset and abort:**
  - Assert `rst_i` asynchronously mid-RUN (idx=2 of 5) → all outputs 0 immediately.
  - Assert `abort_i` in RUN → IDLE next edge, no `valid_o`, no `dump_o`.
  - A following start with `len_i`=1, A={7}, B={3} → 21.
- **Accumulator wrap:** `ACC_WIDTH`=18, unsigned, `len_i`=2, all entries 511 → 2·261121 mod 2^18 = 522242 − 262144 = 260098.

Source files
------------

// File: rtl/cvxif_mac_engine_if.sv
`default_nettype none
// ============================================================================
// Module   : cvxif_mac_engine_if
// Brief    : Start/result handshake and operand-bank bundle of the MAC engine.
// Revision : 1.0 - initial release
// ============================================================================
interface cvxif_mac_engine_if #(
  parameter int NB_OF_REGS = 150,
  parameter int REG_WIDTH  = 9,
  parameter int ACC_WIDTH  = 32,
  parameter int LEN_WIDTH  = 9
);
  logic                                 start_i;
  logic                                 abort_i;
  logic [LEN_WIDTH-1:0]                 len_i;
  logic [NB_OF_REGS-1:0][REG_WIDTH-1:0] a_regs_i;
  logic [NB_OF_REGS-1:0][REG_WIDTH-1:0] b_regs_i;
  logic [ACC_WIDTH-1:0]                 result_o;
  logic                                 valid_o;
  logic                                 ready_i;
  logic                                 busy_o;
  logic                                 dump_o;

  modport master (
    output start_i, abort_i, len_i, a_regs_i, b_regs_i, ready_i,
    input  result_o, valid_o, busy_o, dump_o
  );

  modport slave (
    input  start_i, abort_i, len_i, a_regs_i, b_regs_i, ready_i,
    output result_o, valid_o, busy_o, dump_o
  );
endinterface
`default_nettype wire

// File: rtl/cvxif_mac_engine.sv
`default_nettype none
// ============================================================================
// Module   : cvxif_mac_engine
// Brief    : Dot product of two register banks, one element per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module cvxif_mac_engine #(
  parameter int NB_OF_REGS  = 150,
  parameter int REG_WIDTH   = 9,
  parameter int SIGNED_REGS = 0,
  parameter int ACC_WIDTH   = 32,
  parameter int LEN_WIDTH   = 9
) (
  input wire                clk_i,
  input wire                rst_i,
  cvxif_mac_engine_if.slave bus
);

  localparam int CNT_W  = $clog2(NB_OF_REGS + 1);
  localparam int PROD_W = 2 * REG_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  logic [CNT_W-1:0]      r_idx;
  logic [CNT_W-1:0]      r_len_q;
  logic [ACC_WIDTH-1:0]  r_acc;
  logic [PROD_W-1:0]     r_prod;
  logic                  r_pv;
  logic                  r_valid;
  logic                  r_busy;
  logic                  r_dump;

  logic [REG_WIDTH-1:0]  w_a;
  logic [REG_WIDTH-1:0]  w_b;
  logic                  w_a_sign;
  logic                  w_b_sign;
  logic [PROD_W-1:0]     w_a_ext;
  logic [PROD_W-1:0]     w_b_ext;
  logic [PROD_W-1:0]     w_prod;
  logic                  w_prod_sign;
  logic [ACC_WIDTH-1:0]  w_prod_ext;
  logic [ACC_WIDTH-1:0]  w_acc_sum;
  logic [31:0]           w_len_wide;
  logic [CNT_W-1:0]      w_len_clamp;

  assign w_a      = bus.a_regs_i[r_idx];
  assign w_b      = bus.b_regs_i[r_idx];
  assign w_a_sign = (SIGNED_REGS != 0) && w_a[REG_WIDTH-1];
  assign w_b_sign = (SIGNED_REGS != 0) && w_b[REG_WIDTH-1];
  assign w_a_ext  = {{REG_WIDTH{w_a_sign}}, w_a};
  assign w_b_ext  = {{REG_WIDTH{w_b_sign}}, w_b};
  // Low PROD_W bits of the widened product are exact for both signednesses.
  assign w_prod   = w_a_ext * w_b_ext;

  assign w_prod_sign = (SIGNED_REGS != 0) && r_prod[PROD_W-1];

  generate
    if (ACC_WIDTH > PROD_W) begin : g_ext_wide
      assign w_prod_ext = {{(ACC_WIDTH - PROD_W){w_prod_sign}}, r_prod};
    end else begin : g_ext_exact
      assign w_prod_ext = r_prod;
    end
  endgenerate

  assign w_acc_sum   = r_acc + w_prod_ext;
  assign w_len_wide  = 32'(bus.len_i);
  assign w_len_clamp = CNT_W'((w_len_wide > 32'(NB_OF_REGS)) ? 32'(NB_OF_REGS) : w_len_wide);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_len_q <= '0;
      r_acc   <= '0;
      r_prod  <= '0;
      r_pv    <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_dump  <= 1'b0;
    end else begin
      r_dump <= 1'b0;
      if (bus.abort_i) begin
        r_state <= ST_IDLE;
        r_pv    <= 1'b0;
        r_valid <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (bus.start_i) begin
              r_len_q <= w_len_clamp;
              r_acc   <= '0;
              r_idx   <= '0;
              r_pv    <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= (w_len_clamp != '0) ? ST_RUN : ST_DRAIN;
            end
          end
          ST_RUN: begin
            r_prod <= w_prod;
            r_pv   <= 1'b1;
            r_idx  <= r_idx + CNT_W'(1);
            if (r_pv) begin
              r_acc <= w_acc_sum;
            end
            if (r_idx == r_len_q - CNT_W'(1)) begin
              r_state <= ST_DRAIN;
            end
          end
          ST_DRAIN: begin
            if (r_pv) begin
              r_acc <= w_acc_sum;
            end
            r_pv    <= 1'b0;
            r_valid <= 1'b1;
            r_state <= ST_DONE;
          end
          ST_DONE: begin
            if (bus.ready_i) begin
              r_valid <= 1'b0;
              r_busy  <= 1'b0;
              r_dump  <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  // The accumulator is frozen outside RUN/DRAIN, so it doubles as the result.
  assign bus.result_o = r_acc;
  assign bus.valid_o  = r_valid;
  assign bus.busy_o   = r_busy;
  assign bus.dump_o   = r_dump;

endmodule
`default_nettype wire

// File: tb/tb_cvxif_mac_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_cvxif_mac_engine
// Brief    : Random and directed dot products on three engine variants.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cvxif_mac_engine;

  localparam int NB = 150;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic ready = 1'b0;
  logic [8:0] len_in = '0;
  logic [NB-1:0][8:0] a_bank;
  logic [NB-1:0][8:0] b_bank;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cvxif_mac_engine_if #(.NB_OF_REGS(NB), .REG_WIDTH(9), .ACC_WIDTH(32), .LEN_WIDTH(9)) bus_u ();
  cvxif_mac_engine_if #(.NB_OF_REGS(NB), .REG_WIDTH(9), .ACC_WIDTH(32), .LEN_WIDTH(9)) bus_s ();
  cvxif_mac_engine_if #(.NB_OF_REGS(NB), .REG_WIDTH(9), .ACC_WIDTH(18), .LEN_WIDTH(9)) bus_w ();

  cvxif_mac_engine #(.NB_OF_REGS(NB), .REG_WIDTH(9), .SIGNED_REGS(0), .ACC_WIDTH(32), .LEN_WIDTH(9))
    u_dut_u (.clk_i(clk), .rst_i(rst), .bus(bus_u.slave));
  cvxif_mac_engine #(.NB_OF_REGS(NB), .REG_WIDTH(9), .SIGNED_REGS(1), .ACC_WIDTH(32), .LEN_WIDTH(9))
    u_dut_s (.clk_i(clk), .rst_i(rst), .bus(bus_s.slave));
  cvxif_mac_engine #(.NB_OF_REGS(NB), .REG_WIDTH(9), .SIGNED_REGS(0), .ACC_WIDTH(18), .LEN_WIDTH(9))
    u_dut_w (.clk_i(clk), .rst_i(rst), .bus(bus_w.slave));

  assign bus_u.start_i = start;  assign bus_s.start_i = start;  assign bus_w.start_i = start;
  assign bus_u.abort_i = abort;  assign bus_s.abort_i = abort;  assign bus_w.abort_i = abort;
  assign bus_u.ready_i = ready;  assign bus_s.ready_i = ready;  assign bus_w.ready_i = ready;
  assign bus_u.len_i   = len_in; assign bus_s.len_i   = len_in; assign bus_w.len_i   = len_in;
  assign bus_u.a_regs_i = a_bank; assign bus_s.a_regs_i = a_bank; assign bus_w.a_regs_i = a_bank;
  assign bus_u.b_regs_i = b_bank; assign bus_s.b_regs_i = b_bank; assign bus_w.b_regs_i = b_bank;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer sum of element products, reduced modulo 2^acc_w.
  function automatic logic [63:0] model_dot(input int len, input bit sgn, input int acc_w);
    longint sum = 0;
    int n = (len > NB) ? NB : len;
    for (int i = 0; i < n; i++) begin
      longint x = longint'(a_bank[i]);
      longint y = longint'(b_bank[i]);
      if (sgn && x >= 256) x -= 512;
      if (sgn && y >= 256) y -= 512;
      sum += x * y;
    end
    return 64'(sum) & ((64'd1 << acc_w) - 64'd1);
  endfunction

  task automatic fill_rand();
    for (int i = 0; i < NB; i++) begin
      a_bank[i] = 9'($urandom);
      b_bank[i] = 9'($urandom);
    end
  endtask

  task automatic fill_const(input logic [8:0] v);
    for (int i = 0; i < NB; i++) begin
      a_bank[i] = v;
      b_bank[i] = v;
    end
  endtask

  // Called at a negedge; returns at a negedge with the engine idle.
  task automatic run_txn(input int len, input int hold, input bit poke_start,
                         output logic [31:0] res_u);
    int cyc = 0;
    int lq = (len > NB) ? NB : len;
    logic [31:0] held;
    len_in = 9'(len);
    start  = 1'b1;
    do begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
    end while (!bus_u.valid_o && cyc < 400);
    check_val("latency", 64'(cyc), 64'(lq + 2));
    check_val("res_unsigned", 64'(bus_u.result_o), model_dot(len, 1'b0, 32));
    check_val("res_signed", 64'(bus_s.result_o), model_dot(len, 1'b1, 32));
    check_val("res_wrap18", 64'(bus_w.result_o), model_dot(len, 1'b0, 18));
    check_val("done_busy", 64'(bus_u.busy_o), 64'd1);
    res_u = bus_u.result_o;
    held  = bus_u.result_o;
    for (int k = 0; k < hold; k++) begin
      if (poke_start && k == 0) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_val("bp_valid", 64'(bus_u.valid_o), 64'd1);
      check_val("bp_result", 64'(bus_u.result_o), 64'(held));
      check_val("bp_dump", 64'(bus_u.dump_o), 64'd0);
      check_val("bp_busy", 64'(bus_u.busy_o), 64'd1);
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    check_val("hs_valid", 64'(bus_u.valid_o), 64'd0);
    check_val("hs_dump", 64'(bus_u.dump_o), 64'd1);
    check_val("hs_dump_s", 64'(bus_s.dump_o), 64'd1);
    check_val("hs_busy", 64'(bus_u.busy_o), 64'd0);
    @(negedge clk);
    check_val("dump_width", 64'(bus_u.dump_o), 64'd0);
    check_val("idle_busy", 64'(bus_u.busy_o), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int seen_valid;
    int seen_dump;
    int cyc;
    fill_rand();
    repeat (3) @(negedge clk);
    check_val("rst_valid", 64'(bus_u.valid_o), 64'd0);
    check_val("rst_busy", 64'(bus_u.busy_o), 64'd0);
    check_val("rst_dump", 64'(bus_u.dump_o), 64'd0);
    check_val("rst_result", 64'(bus_u.result_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Unsigned basic 1*4+2*5+3*6
    fill_rand();
    a_bank[0] = 9'd1; a_bank[1] = 9'd2; a_bank[2] = 9'd3;
    b_bank[0] = 9'd4; b_bank[1] = 9'd5; b_bank[2] = 9'd6;
    run_txn(3, 0, 1'b0, r);
    check_val("basic_32", 64'(r), 64'd32);

    // Signed pair: -1*5 + 2*-2
    fill_rand();
    a_bank[0] = 9'h1FF; a_bank[1] = 9'h002;
    b_bank[0] = 9'd5;   b_bank[1] = 9'h1FE;
    run_txn(2, 1, 1'b0, r);
    check_val("signed_fff7", 64'(bus_s.result_o), 64'hFFFFFFF7);

    fill_rand();
    run_txn(0, 0, 1'b0, r);
    check_val("empty_zero", 64'(r), 64'd0);

    fill_const(9'd1);
    run_txn(200, 0, 1'b0, r);
    check_val("clamp_150", 64'(r), 64'd150);

    fill_const(9'd511);
    run_txn(2, 5, 1'b1, r);
    check_val("wrap_260098", 64'(bus_w.result_o), 64'd260098);

    // Asynchronous reset part-way through RUN
    fill_const(9'd3);
    len_in = 9'd5;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_val("arst_valid", 64'(bus_u.valid_o), 64'd0);
    check_val("arst_busy", 64'(bus_u.busy_o), 64'd0);
    check_val("arst_dump", 64'(bus_u.dump_o), 64'd0);
    check_val("arst_result", 64'(bus_u.result_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Abort in RUN, then nothing must surface
    len_in = 9'd5;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_val("abort_busy", 64'(bus_u.busy_o), 64'd0);
    seen_valid = 0;
    seen_dump  = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (bus_u.valid_o) seen_valid++;
      if (bus_u.dump_o) seen_dump++;
    end
    check_val("abort_no_valid", 64'(seen_valid), 64'd0);
    check_val("abort_no_dump", 64'(seen_dump), 64'd0);
    fill_rand();
    a_bank[0] = 9'd7;
    b_bank[0] = 9'd3;
    run_txn(1, 0, 1'b0, r);
    check_val("after_abort_21", 64'(r), 64'd21);

    // Abort coinciding with the handshake suppresses the dump
    len_in = 9'd1;
    start  = 1'b1;
    cyc    = 0;
    do begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
    end while (!bus_u.valid_o && cyc < 50);
    check_val("abhs_reach_done", 64'(bus_u.valid_o), 64'd1);
    ready = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    abort = 1'b0;
    check_val("abhs_dump", 64'(bus_u.dump_o), 64'd0);
    check_val("abhs_valid", 64'(bus_u.valid_o), 64'd0);
    check_val("abhs_busy", 64'(bus_u.busy_o), 64'd0);
    @(negedge clk);

    for (int t = 0; t < 25; t++) begin
      int len;
      fill_rand();
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(140, 200)) : int'($urandom_range(0, 20));
      run_txn(len, int'($urandom_range(0, 3)), 1'($urandom), r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
